// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment driver: glyphs, bit positions,
// and an index-width helper. Segment byte layout is {a,b,c,d,e,f,g,dp}.
package seg_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] GLYPH_0   = 8'hFC;
  localparam logic [7:0] GLYPH_1   = 8'h60;
  localparam logic [7:0] GLYPH_2   = 8'hDA;
  localparam logic [7:0] GLYPH_3   = 8'hF2;
  localparam logic [7:0] GLYPH_4   = 8'h66;
  localparam logic [7:0] GLYPH_5   = 8'hB6;
  localparam logic [7:0] GLYPH_6   = 8'hBE;
  localparam logic [7:0] GLYPH_7   = 8'hE0;
  localparam logic [7:0] GLYPH_8   = 8'hFE;
  localparam logic [7:0] GLYPH_9   = 8'hE6;
  localparam logic [7:0] GLYPH_E   = 8'h9E;
  localparam logic [7:0] GLYPH_OFF = 8'h00;

  // Width able to hold 0..n-1, never below one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Nibble to segment pattern; non-decimal nibbles render as 'E'.
// The dp bit of the returned glyph is always clear.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] glyph
);

  always_comb begin
    glyph = GLYPH_E;
    case (nibble)
      4'd0:    glyph = GLYPH_0;
      4'd1:    glyph = GLYPH_1;
      4'd2:    glyph = GLYPH_2;
      4'd3:    glyph = GLYPH_3;
      4'd4:    glyph = GLYPH_4;
      4'd5:    glyph = GLYPH_5;
      4'd6:    glyph = GLYPH_6;
      4'd7:    glyph = GLYPH_7;
      4'd8:    glyph = GLYPH_8;
      4'd9:    glyph = GLYPH_9;
      default: glyph = GLYPH_E;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// N-digit time-multiplexed 7-segment scanner with guard time and frame-synchronous
// buffer swap. Define SEG_BLINK_EN to enable per-digit blinking.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 100000,
  parameter int GUARD_CYCLES = 2000,
  parameter int BLINK_CYCLES = 50000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int CW = idx_width(SLOT_CYCLES);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          wrap;
  logic          last;
  logic          boundary;
  logic          guard;

  logic [4*NUM_DIGITS-1:0] stg_dig;
  logic [NUM_DIGITS-1:0]   stg_dp;
  logic [NUM_DIGITS-1:0]   stg_blank;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] sh_dig;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;

  logic [3:0]            nib;
  logic [7:0]            glyph;
  logic                  hide;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign wrap     = (cnt == CW'(SLOT_CYCLES - 1));
  assign last     = (idx == IW'(NUM_DIGITS - 1));
  assign boundary = wrap && last;
  assign guard    = (cnt < CW'(GUARD_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= last ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Staging absorbs loads at any time; shadow only changes on the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_dig   <= '0;
      stg_dp    <= '0;
      stg_blank <= '1;
      pending   <= 1'b0;
      sh_dig    <= '0;
      sh_dp     <= '0;
      sh_blank  <= '1;
    end else begin
      if (load) begin
        stg_dig   <= digits_in;
        stg_dp    <= dp_in;
        stg_blank <= blank_in;
      end
      if (boundary) begin
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
      if (boundary && load) begin
        sh_dig   <= digits_in;
        sh_dp    <= dp_in;
        sh_blank <= blank_in;
      end else if (boundary && pending) begin
        sh_dig   <= stg_dig;
        sh_dp    <= stg_dp;
        sh_blank <= stg_blank;
      end
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BW = idx_width(BLINK_CYCLES);

  logic [BW-1:0]         bcnt;
  logic                  phase;
  logic [NUM_DIGITS-1:0] stg_blink;
  logic [NUM_DIGITS-1:0] sh_blink;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (bcnt == BW'(BLINK_CYCLES - 1)) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_blink <= '0;
      sh_blink  <= '0;
    end else begin
      if (load) begin
        stg_blink <= blink_in;
      end
      if (boundary && load) begin
        sh_blink <= blink_in;
      end else if (boundary && pending) begin
        sh_blink <= stg_blink;
      end
    end
  end

  assign hide = ~phase & sh_blink[idx];
`else
  localparam int unused_blink_cycles = BLINK_CYCLES;
  logic          unused_blink;

  assign unused_blink = ^blink_in;
  assign hide         = 1'b0;
`endif

  assign nib = sh_dig[{idx, 2'b00} +: 4];

  seg_glyph_decode u_dec (
    .nibble (nib),
    .glyph  (glyph)
  );

  always_comb begin
    an_next  = '0;
    seg_next = GLYPH_OFF;
    if (!guard) begin
      an_next = NUM_DIGITS'(1) << idx;
      if (!sh_blank[idx] && !hide) begin
        seg_next         = glyph;
        seg_next[SEG_DP] = sh_dp[idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out    <= GLYPH_OFF;
      an_out     <= '0;
      frame_done <= 1'b0;
    end else begin
      seg_out    <= seg_next;
      an_out     <= an_next;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: 4 digits, 8-cycle slots, 2-cycle guard.
// Blink expectations follow SEG_BLINK_EN when it is defined.
module tb_seg_scan_display;

  localparam int N = 4;
  localparam int S = 8;
  localparam int G = 2;
  localparam int B = 64;

`ifdef SEG_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [4*N-1:0] digits_in;
  logic [N-1:0]  dp_in;
  logic [N-1:0]  blank_in;
  logic [N-1:0]  blink_in;
  logic [7:0]    seg_out;
  logic [N-1:0]  an_out;
  logic          frame_done;

  int total = 0;
  int bad = 0;
  int pos = 0;
  int gcount = 0;
  logic [31:0] shown = '0;
  logic [3:0]  bmask = '0;

  always #5 clk = ~clk;

  seg_scan_display #(
    .NUM_DIGITS   (N),
    .SLOT_CYCLES  (S),
    .GUARD_CYCLES (G),
    .BLINK_CYCLES (B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .blink_in   (blink_in),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s pos=%0d got=%h exp=%h", tag, pos, got, exp);
    end
  endtask

  // One clock; checks outputs against the expected scan position.
  task automatic tick();
    int c;
    int d;
    logic [7:0] es;
    logic [3:0] ea;
    logic ph;
    @(posedge clk);
    #1;
    c  = pos % S;
    d  = pos / S;
    ph = ((gcount / B) % 2) == 0;
    ea = (c < G) ? 4'b0000 : 4'(1 << d);
    es = shown[d*8 +: 8];
    if (c < G) es = 8'h00;
    if (BLINK_ON && bmask[d] && !ph) es = 8'h00;
    chk("an", {4'b0, an_out}, {4'b0, ea});
    chk("seg", seg_out, es);
    chk("frame_done", {7'b0, frame_done}, {7'b0, pos == N*S-1});
    pos = (pos + 1) % (N*S);
    gcount++;
  endtask

  task automatic do_load(input logic [15:0] dg, input logic [3:0] dp,
                         input logic [3:0] bl, input logic [3:0] bk);
    digits_in = dg;
    dp_in     = dp;
    blank_in  = bl;
    blink_in  = bk;
    load      = 1'b1;
    tick();
    load      = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    load      = 1'b0;
    digits_in = '0;
    dp_in     = '0;
    blank_in  = '0;
    blink_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", {4'b0, an_out}, 8'h00);
    chk("rst_seg", seg_out, 8'h00);
    chk("rst_fd", {7'b0, frame_done}, 8'h00);
    rst = 1'b0;

    // dark frame, then a frame during which 3210 is loaded
    shown = 32'h0;
    repeat (32) tick();
    repeat (10) tick();
    do_load(16'h3210, 4'b0000, 4'b0000, 4'b0000);
    repeat (21) tick();

    // 3210 visible; two mid-frame loads, last wins next frame
    shown = 32'hF2DA60FC;
    repeat (4) tick();
    do_load(16'h9999, 4'b0000, 4'b0000, 4'b0000);
    repeat (15) tick();
    do_load(16'h8888, 4'b0000, 4'b0000, 4'b0000);
    repeat (11) tick();

    // all 8s; load coincident with the boundary
    shown = 32'hFEFEFEFE;
    repeat (31) tick();
    do_load(16'hABCD, 4'b0010, 4'b0000, 4'b0000);

    shown = 32'h9E9E9F9E;
    repeat (32) tick();

    // pending load then reset inside slot 2
    repeat (18) tick();
    do_load(16'h7777, 4'b0000, 4'b0000, 4'b0000);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_an", {4'b0, an_out}, 8'h00);
    chk("mid_rst_seg", seg_out, 8'h00);
    chk("mid_rst_fd", {7'b0, frame_done}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    pos    = 0;
    gcount = 0;
    shown  = 32'h0;
    repeat (64) tick();

    // blink mask on digit 0 with digits 0005
    repeat (31) tick();
    do_load(16'h0005, 4'b0000, 4'b0000, 4'b0001);
    shown = 32'hFCFCFCB6;
    bmask = 4'b0001;
    repeat (96) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
